// File: rtl/operand_fetch.sv
// operand_fetch: RV32I decode / operand-fetch stage with a pending-write scoreboard and a registered EX bundle.
// Build option: define OPERAND_FETCH_BYPASS_EN to forward same-cycle write-back data into the operands.
module operand_fetch #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic [AW-1:0]   rf_a0,
    output logic [AW-1:0]   rf_a1,
    input  logic [XLEN-1:0] rf_q0,
    input  logic [XLEN-1:0] rf_q1,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_wr,
    input  logic [XLEN-1:0] wb_din,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_rs1_val,
    output logic [XLEN-1:0] out_rs2_val,
    output logic [XLEN-1:0] out_imm,
    output logic [AW-1:0]   out_rd,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7
);
    localparam int NREG = 1 << AW;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Instruction fields
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic [6:0]    funct7;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [AW-1:0] rd_field;
    logic [AW-1:0] rd;

    assign opcode   = in_instr[6:0];
    assign funct3   = in_instr[14:12];
    assign funct7   = in_instr[31:25];
    assign rs1      = in_instr[19:15];
    assign rs2      = in_instr[24:20];
    assign rd_field = in_instr[11:7];

    assign rf_a0 = rs1;
    assign rf_a1 = rs2;

    // Decode: source usage, destination and immediate
    logic        use_rs1;
    logic        use_rs2;
    logic        writes_rd;
    logic [31:0] imm32;

    always_comb begin
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        writes_rd = 1'b0;
        imm32     = '0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                writes_rd = 1'b1;
                imm32     = {in_instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                writes_rd = 1'b1;
                imm32     = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                             in_instr[20], in_instr[30:21], 1'b0};
            end
            OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
                use_rs1   = 1'b1;
                writes_rd = 1'b1;
                imm32     = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            OPC_STORE: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            OPC_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0};
            end
            OPC_OP: begin
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                writes_rd = 1'b1;
            end
            default: ;
        endcase
    end

    assign rd = writes_rd ? rd_field : '0;

    logic [XLEN-1:0] imm_ext;
    assign imm_ext = XLEN'(signed'(imm32));

    // Scoreboard and output registers
    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic [XLEN-1:0] rs1_val_q, rs1_val_d;
    logic [XLEN-1:0] rs2_val_q, rs2_val_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [AW-1:0]   out_rd_q, out_rd_d;
    logic [6:0]      opcode_q, opcode_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [6:0]      funct7_q, funct7_d;

    // Operand selection and hazard detection
    logic            wb_hit_rs1;
    logic            wb_hit_rs2;
    logic            wb_hit_rd;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            haz_rs1;
    logic            haz_rs2;
    logic            haz_rd;
    logic            hazard;
    logic            fire;

    assign wb_hit_rs1 = wb_we && (wb_wr == rs1);
    assign wb_hit_rs2 = wb_we && (wb_wr == rs2);
    assign wb_hit_rd  = wb_we && (wb_wr == rd);

`ifdef OPERAND_FETCH_BYPASS_EN
    // x0 is a real storage location in the file, so it is masked before the bypass.
    assign rs1_val = (rs1 == '0) ? '0 : (wb_hit_rs1 ? wb_din : rf_q0);
    assign rs2_val = (rs2 == '0) ? '0 : (wb_hit_rs2 ? wb_din : rf_q1);
    assign haz_rs1 = use_rs1 && (rs1 != '0) && pend_q[rs1] && !wb_hit_rs1;
    assign haz_rs2 = use_rs2 && (rs2 != '0) && pend_q[rs2] && !wb_hit_rs2;
    assign haz_rd  = (rd != '0) && pend_q[rd];
`else
    // Without forwarding, wait until the write-back has landed in the file.
    logic wb_din_unused;
    assign wb_din_unused = ^wb_din;
    assign rs1_val = (rs1 == '0) ? '0 : rf_q0;
    assign rs2_val = (rs2 == '0) ? '0 : rf_q1;
    assign haz_rs1 = use_rs1 && (rs1 != '0) && (pend_q[rs1] || wb_hit_rs1);
    assign haz_rs2 = use_rs2 && (rs2 != '0) && (pend_q[rs2] || wb_hit_rs2);
    assign haz_rd  = (rd != '0) && (pend_q[rd] || wb_hit_rd);
`endif

    assign hazard   = haz_rs1 || haz_rs2 || haz_rd;
    assign in_ready = !hazard && (!out_valid_q || out_ready) && !flush;
    assign fire     = in_valid && in_ready;

    // Per-register pending bit: a new writer beats a same-cycle write-back or flush clear.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_pend
        if (gi == 0) begin : g_x0
            assign pend_d[gi] = 1'b0;
        end else begin : g_xn
            logic clr_wb;
            logic clr_flush;
            logic set_fire;
            assign clr_wb    = wb_we && (wb_wr == AW'(gi));
            assign clr_flush = flush && out_valid_q && (out_rd_q == AW'(gi));
            assign set_fire  = fire && (rd == AW'(gi));
            assign pend_d[gi] = set_fire || (pend_q[gi] && !clr_wb && !clr_flush);
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        rs1_val_d   = rs1_val_q;
        rs2_val_d   = rs2_val_q;
        imm_d       = imm_q;
        out_rd_d    = out_rd_q;
        opcode_d    = opcode_q;
        funct3_d    = funct3_q;
        funct7_d    = funct7_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (fire) begin
            out_valid_d = 1'b1;
            out_pc_d    = in_pc;
            rs1_val_d   = rs1_val;
            rs2_val_d   = rs2_val;
            imm_d       = imm_ext;
            out_rd_d    = rd;
            opcode_d    = opcode;
            funct3_d    = funct3;
            funct7_d    = funct7;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q      <= '0;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            rs1_val_q   <= '0;
            rs2_val_q   <= '0;
            imm_q       <= '0;
            out_rd_q    <= '0;
            opcode_q    <= '0;
            funct3_q    <= '0;
            funct7_q    <= '0;
        end else begin
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            rs1_val_q   <= rs1_val_d;
            rs2_val_q   <= rs2_val_d;
            imm_q       <= imm_d;
            out_rd_q    <= out_rd_d;
            opcode_q    <= opcode_d;
            funct3_q    <= funct3_d;
            funct7_q    <= funct7_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_pc      = out_pc_q;
    assign out_rs1_val = rs1_val_q;
    assign out_rs2_val = rs2_val_q;
    assign out_imm     = imm_q;
    assign out_rd      = out_rd_q;
    assign out_opcode  = opcode_q;
    assign out_funct3  = funct3_q;
    assign out_funct7  = funct7_q;

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: scoreboard bench for operand_fetch with a behavioural register file.
// Scenario tasks run in sequence; a negedge monitor compares every accepted EX bundle.
`timescale 1ns/1ps
module tb_operand_fetch;
    localparam logic [6:0] OPC_OPIMM = 7'h13;
    localparam logic [6:0] OPC_OP    = 7'h33;
    localparam logic [6:0] OPC_LOAD  = 7'h03;
    localparam logic [6:0] OPC_STORE = 7'h23;
    localparam logic [6:0] OPC_JALR  = 7'h67;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  rf_a0, rf_a1;
    logic [31:0] rf_q0, rf_q1;
    logic        wb_we;
    logic [4:0]  wb_wr;
    logic [31:0] wb_din;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
    logic [4:0]  out_rd;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    operand_fetch #(.XLEN(32), .AW(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .rf_a0(rf_a0), .rf_a1(rf_a1), .rf_q0(rf_q0), .rf_q1(rf_q1),
        .wb_we(wb_we), .wb_wr(wb_wr), .wb_din(wb_din), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_imm(out_imm),
        .out_rd(out_rd), .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7)
    );

    // Register file: r[i] = A000_00ii after reset, r[0] holds junk that must never reach EX.
    logic [31:0] rf_mem [32];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++)
                rf_mem[i] <= (i == 0) ? 32'hDEAD_BEEF : (32'hA000_0000 | 32'(i));
        end else if (wb_we) begin
            rf_mem[wb_wr] <= wb_din;
        end
    end
    assign rf_q0 = rf_mem[rf_a0];
    assign rf_q1 = rf_mem[rf_a1];

    typedef struct {
        logic [31:0] pc, v1, v2, imm;
        logic [4:0]  rd;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (rst === 1'b0 && flush === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL bundle: unexpected bundle pc=%h rd=%0d, none expected", out_pc, out_rd);
            end else begin
                mon_e = exp_q.pop_front();
                if ({out_pc, out_rs1_val, out_rs2_val, out_imm, out_rd, out_opcode, out_funct3, out_funct7} !==
                    {mon_e.pc, mon_e.v1, mon_e.v2, mon_e.imm, mon_e.rd, mon_e.op, mon_e.f3, mon_e.f7}) begin
                    errors++;
                    $display("FAIL bundle: got pc=%h rs1=%h rs2=%h imm=%h rd=%0d op=%h f3=%h f7=%h, expected pc=%h rs1=%h rs2=%h imm=%h rd=%0d op=%h f3=%h f7=%h",
                             out_pc, out_rs1_val, out_rs2_val, out_imm, out_rd, out_opcode, out_funct3, out_funct7,
                             mon_e.pc, mon_e.v1, mon_e.v2, mon_e.imm, mon_e.rd, mon_e.op, mon_e.f3, mon_e.f7);
                end else begin
                    $display("bundle ok: pc=%h rs1=%h rs2=%h imm=%h rd=%0d", out_pc, out_rs1_val, out_rs2_val, out_imm, out_rd);
                end
            end
        end
    end

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [6:0] op);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
    endfunction

    task automatic push(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] v1,
                        input logic [31:0] v2, input logic [31:0] imm, input logic [4:0] rd);
        exp_t e;
        e.pc = pc; e.v1 = v1; e.v2 = v2; e.imm = imm; e.rd = rd;
        e.op = instr[6:0]; e.f3 = instr[14:12]; e.f7 = instr[31:25];
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_instr = '0; in_pc = '0;
        wb_we = 1'b0; wb_wr = '0; wb_din = '0;
        flush = 1'b0; out_ready = 1'b1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1; in_instr = instr; in_pc = pc;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: out_valid=%b expected 0", out_valid); end
        checks++;
        if ({out_pc, out_rs1_val, out_rs2_val, out_imm, out_rd, out_opcode, out_funct3, out_funct7} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: pc=%h rs1=%h rs2=%h imm=%h rd=%0d expected all zero",
                     out_pc, out_rs1_val, out_rs2_val, out_imm, out_rd);
        end
        rst = 1'b0;
        exp_q.delete();
        drive(enc_i(12'd5, 5'd0, 3'd0, 5'd1, OPC_OPIMM), 32'h100);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: in_ready=%b expected 1", in_ready); end
        push(in_instr, 32'h100, 32'h0, 32'hA000_0005, 32'd5, 5'd1);
        tick();
        checks++;
        if ({out_valid, out_rd, out_imm} !== {1'b1, 5'd1, 32'd5}) begin
            errors++;
            $display("FAIL basic_latency: valid=%b rd=%0d imm=%h expected valid=1 rd=1 imm=5", out_valid, out_rd, out_imm);
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: out_valid=%b expected 0", out_valid); end
    endtask

    task automatic test_raw_hazard();
        logic [31:0] add_i;
        do_reset();
        drive(enc_i(12'd5, 5'd0, 3'd0, 5'd1, OPC_OPIMM), 32'h110);
        push(in_instr, 32'h110, 32'h0, 32'hA000_0005, 32'd5, 5'd1);
        tick();
        add_i = enc_r(7'd0, 5'd1, 5'd1, 3'd0, 5'd2, OPC_OP);
        drive(add_i, 32'h114);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_stall: in_ready=%b expected 0", in_ready); end
        tick();
        wb_we = 1'b1; wb_wr = 5'd1; wb_din = 32'h5;
        #1;
`ifdef OPERAND_FETCH_BYPASS_EN
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_bypass_fire: in_ready=%b expected 1", in_ready); end
        push(add_i, 32'h114, 32'h5, 32'h5, 32'h0, 5'd2);
        tick();
        wb_we = 1'b0;
`else
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_wait_wb: in_ready=%b expected 0", in_ready); end
        tick();
        wb_we = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_fire_rf: in_ready=%b expected 1", in_ready); end
        push(add_i, 32'h114, 32'h5, 32'h5, 32'h0, 5'd2);
        tick();
`endif
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        drive(enc_i(12'd7, 5'd0, 3'd0, 5'd3, OPC_OPIMM), 32'h200);
        push(in_instr, 32'h200, 32'h0, 32'hA000_0007, 32'd7, 5'd3);
        tick();
        drive(enc_i(12'd9, 5'd0, 3'd0, 5'd4, OPC_OPIMM), 32'h204);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if ({in_ready, out_valid, out_pc, out_imm, out_rd} !== {1'b0, 1'b1, 32'h200, 32'd7, 5'd3}) begin
                errors++;
                $display("FAIL hold_%0d: ready=%b valid=%b pc=%h imm=%h rd=%0d expected ready=0 valid=1 pc=200 imm=7 rd=3",
                         k, in_ready, out_valid, out_pc, out_imm, out_rd);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL release_fire: in_ready=%b expected 1", in_ready); end
        push(in_instr, 32'h204, 32'h0, 32'hA000_0009, 32'd9, 5'd4);
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] instr_t [6];
        logic [31:0] v1_t [6];
        logic [31:0] v2_t [6];
        logic [31:0] imm_t [6];
        logic [4:0]  rd_t [6];
        instr_t[0] = 32'h1234_55B7; v1_t[0] = 32'hA000_0008; v2_t[0] = 32'hA000_0003; imm_t[0] = 32'h1234_5000; rd_t[0] = 5'd11;
        instr_t[1] = 32'hFFFF_F697; v1_t[1] = 32'hA000_001F; v2_t[1] = 32'hA000_001F; imm_t[1] = 32'hFFFF_F000; rd_t[1] = 5'd13;
        instr_t[2] = 32'hFF9F_F0EF; v1_t[2] = 32'hA000_001F; v2_t[2] = 32'hA000_0019; imm_t[2] = 32'hFFFF_FFF8; rd_t[2] = 5'd1;
        instr_t[3] = 32'h0000_0863; v1_t[3] = 32'h0;         v2_t[3] = 32'h0;         imm_t[3] = 32'd16;        rd_t[3] = 5'd0;
        instr_t[4] = enc_i(12'd12, 5'd2, 3'd0, 5'd5, OPC_JALR);
                                    v1_t[4] = 32'hA000_0002; v2_t[4] = 32'hA000_000C; imm_t[4] = 32'd12;        rd_t[4] = 5'd5;
        instr_t[5] = 32'hFE41_CEE3; v1_t[5] = 32'hA000_0003; v2_t[5] = 32'hA000_0004; imm_t[5] = 32'hFFFF_FFFC; rd_t[5] = 5'd0;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(instr_t[k], 32'h300 + 32'(k * 4));
            #1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d: in_ready=%b expected 1", k, in_ready); end
            push(instr_t[k], 32'h300 + 32'(k * 4), v1_t[k], v2_t[k], imm_t[k], rd_t[k]);
            tick();
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0;
        drive(enc_i(12'd1, 5'd0, 3'd0, 5'd3, OPC_OPIMM), 32'h400);
        push(in_instr, 32'h400, 32'h0, 32'hA000_0001, 32'd1, 5'd3);
        tick();
        flush = 1'b1;
        out_ready = 1'b1;
        drive(enc_i(12'd2, 5'd0, 3'd0, 5'd6, OPC_OPIMM), 32'h404);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_blocks_fire: in_ready=%b expected 0", in_ready); end
        tick();
        flush = 1'b0;
        void'(exp_q.pop_front());
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop: out_valid=%b expected 0", out_valid); end
        drive(enc_r(7'd0, 5'd0, 5'd3, 3'd0, 5'd5, OPC_OP), 32'h408);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_clears_pend: in_ready=%b expected 1", in_ready); end
        push(in_instr, 32'h408, 32'hA000_0003, 32'h0, 32'h0, 5'd5);
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_x0_store();
        do_reset();
        drive(enc_r(7'd0, 5'd0, 5'd0, 3'd0, 5'd4, OPC_OP), 32'h500);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL x0_ready: in_ready=%b expected 1", in_ready); end
        push(in_instr, 32'h500, 32'h0, 32'h0, 32'h0, 5'd4);
        tick();
        drive(enc_s(12'hFFC, 5'd5, 5'd6, 3'b010, OPC_STORE), 32'h504);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL store_ready: in_ready=%b expected 1", in_ready); end
        push(in_instr, 32'h504, 32'hA000_0006, 32'hA000_0005, 32'hFFFF_FFFC, 5'd0);
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_set_wins();
        logic [31:0] lw_i;
        do_reset();
        lw_i = enc_i(12'd8, 5'd0, 3'b010, 5'd7, OPC_LOAD);
        drive(lw_i, 32'h600);
        wb_we = 1'b1; wb_wr = 5'd7; wb_din = 32'h77;
        #1;
`ifdef OPERAND_FETCH_BYPASS_EN
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL setwin_fire: in_ready=%b expected 1", in_ready); end
        push(lw_i, 32'h600, 32'h0, 32'hA000_0008, 32'd8, 5'd7);
        tick();
        wb_we = 1'b0;
`else
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL setwin_wb_rd_stall: in_ready=%b expected 0", in_ready); end
        tick();
        wb_we = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL setwin_fire: in_ready=%b expected 1", in_ready); end
        push(lw_i, 32'h600, 32'h0, 32'hA000_0008, 32'd8, 5'd7);
        tick();
`endif
        drive(enc_r(7'd0, 5'd0, 5'd7, 3'd0, 5'd8, OPC_OP), 32'h604);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL setwin_pend7: in_ready=%b expected 0", in_ready); end
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_mid_reset();
        do_reset();
        out_ready = 1'b0;
        drive(enc_i(12'd3, 5'd0, 3'd0, 5'd9, OPC_OPIMM), 32'h700);
        push(in_instr, 32'h700, 32'h0, 32'hA000_0003, 32'd3, 5'd9);
        tick();
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_rst_held: out_valid=%b expected 1", out_valid); end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_drop: out_valid=%b expected 0", out_valid); end
        out_ready = 1'b1;
        drive(enc_r(7'd0, 5'd9, 5'd9, 3'd0, 5'd10, OPC_OP), 32'h704);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_pend_clear: in_ready=%b expected 1", in_ready); end
        push(in_instr, 32'h704, 32'hA000_0009, 32'hA000_0009, 32'h0, 5'd10);
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_raw_hazard();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_x0_store();
        test_set_wins();
        test_mid_reset();
        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d bundles outstanding, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
